// File: rtl/macc_seq_pkg.sv
// Shared definitions for the MACC sequencer: precision defaults, MACC op codes,
// FSM state encoding and op-code decode helpers.
package macc_seq_pkg;

    localparam int PRECISION_OP   = 16;
    localparam int PRECISION_ACC  = 40;
    localparam int PRECISION_FRAC = 0;

    localparam int MACC_LAT = 3;

    localparam logic [2:0] MACC_MUL   = 3'd0;
    localparam logic [2:0] MACC_SQ    = 3'd1;
    localparam logic [2:0] MACC_MACC  = 3'd2;
    localparam logic [2:0] MACC_SQACC = 3'd3;
    localparam logic [2:0] MACC_MADD  = 3'd4;
    localparam logic [2:0] MACC_SQADD = 3'd5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Odd op codes multiply op_0 by itself instead of op_1.
    function automatic logic op_is_square(input logic [2:0] op_code);
        return op_code[0];
    endfunction

    function automatic logic op_is_accumulate(input logic [2:0] op_code);
        return (op_code == MACC_MACC) || (op_code == MACC_SQACC);
    endfunction

    function automatic logic op_is_add(input logic [2:0] op_code);
        return (op_code == MACC_MADD) || (op_code == MACC_SQADD);
    endfunction

endpackage

// File: rtl/macc_seq_macc.sv
// Three-stage multiply/accumulate unit: input register, product register, accumulator.
// Controls travel with their operands, so a clear issued one cycle ahead of an enable lands first.
module macc
    import macc_seq_pkg::*;
#(
    parameter string TYPE      = "FIXED_POINT",
    parameter int    OP_WIDTH  = PRECISION_OP,
    parameter int    ACC_WIDTH = PRECISION_ACC,
    parameter int    OUT_WIDTH = PRECISION_OP,
    parameter int    FRAC_BITS = PRECISION_FRAC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [2:0]                  op_code,
    input  logic signed [OP_WIDTH-1:0]  op_0,
    input  logic signed [OP_WIDTH-1:0]  op_1,
    input  logic signed [OP_WIDTH-1:0]  op_add,
    output logic signed [OUT_WIDTH-1:0] out
);

    localparam int PROD_W = 2 * OP_WIDTH;
    localparam int SHIFT  = (TYPE == "FIXED_POINT") ? FRAC_BITS : 0;

    logic                       r_en1, r_clr1, r_en2, r_clr2;
    logic [2:0]                 r_opc1, r_opc2;
    logic signed [OP_WIDTH-1:0] r_a1, r_b1, r_add1, r_add2;
    logic signed [PROD_W-1:0]   r_prod2;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic signed [OP_WIDTH-1:0]  w_mul_b;
    logic signed [ACC_WIDTH-1:0] w_term, w_base, w_acc_next;

    // Operand selection and next accumulator value.
    always_comb begin
        w_mul_b    = op_is_square(r_opc1) ? r_a1 : r_b1;
        w_term     = ACC_WIDTH'(r_prod2);
        w_base     = '0;
        if (op_is_add(r_opc2)) begin
            w_term = ACC_WIDTH'(r_prod2) + ACC_WIDTH'(r_add2);
        end else begin
            w_term = ACC_WIDTH'(r_prod2);
        end
        if (op_is_accumulate(r_opc2) && !r_clr2) begin
            w_base = r_acc;
        end else begin
            w_base = '0;
        end
        w_acc_next = w_base + w_term;
    end

    // Pipeline stages 1 and 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en1   <= 1'b0;
            r_clr1  <= 1'b0;
            r_opc1  <= 3'd0;
            r_a1    <= '0;
            r_b1    <= '0;
            r_add1  <= '0;
            r_en2   <= 1'b0;
            r_clr2  <= 1'b0;
            r_opc2  <= 3'd0;
            r_prod2 <= '0;
            r_add2  <= '0;
        end else begin
            r_en1   <= enable;
            r_clr1  <= clear;
            r_opc1  <= op_code;
            r_a1    <= op_0;
            r_b1    <= op_1;
            r_add1  <= op_add;
            r_en2   <= r_en1;
            r_clr2  <= r_clr1;
            r_opc2  <= r_opc1;
            r_prod2 <= PROD_W'(r_a1) * PROD_W'(w_mul_b);
            r_add2  <= r_add1;
        end
    end

    // Accumulator stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (r_en2) begin
            r_acc <= w_acc_next;
        end else if (r_clr2) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign out = OUT_WIDTH'(r_acc >>> SHIFT);

endmodule

// File: rtl/macc_seq.sv
// Command-driven sequencer computing dot products or sums of squares on one macc,
// covering its pipeline latency and holding each result until consumed.
module macc_seq
    import macc_seq_pkg::*;
#(
    parameter int OP_WIDTH  = PRECISION_OP,
    parameter int ACC_WIDTH = PRECISION_ACC,
    parameter int OUT_WIDTH = PRECISION_OP,
    parameter int FRAC_BITS = PRECISION_FRAC,
    parameter int LEN_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        cmd_square,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [OP_WIDTH-1:0]  in_op_0,
    input  logic signed [OP_WIDTH-1:0]  in_op_1,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [OUT_WIDTH-1:0] res_data
);

    localparam logic [1:0] DRAIN_LAST = 2'(MACC_LAT - 1);

    logic [2:0]                  r_state;
    logic [LEN_W-1:0]            r_remaining;
    logic                        r_sq;
    logic [1:0]                  r_drain_cnt;
    logic signed [OUT_WIDTH-1:0] r_res_data;

    logic                        w_accept;
    logic [2:0]                  w_op_code;
    logic signed [OUT_WIDTH-1:0] w_macc_out;

    assign cmd_ready = (r_state == S_IDLE);
    assign in_ready  = (r_state == S_STREAM) && (r_remaining != '0);
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign w_accept  = in_valid && in_ready;

    // Op code is held for the whole command so in-flight products keep their mode.
    always_comb begin
        w_op_code = MACC_MUL;
        case (r_state)
            S_CLEAR, S_STREAM, S_DRAIN: w_op_code = r_sq ? MACC_SQACC : MACC_MACC;
            default:                    w_op_code = MACC_MUL;
        endcase
    end

    // Command FSM, element counter, drain counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_sq        <= 1'b0;
            r_drain_cnt <= 2'd0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_remaining <= cmd_len;
                        r_sq        <= cmd_square;
                        r_state     <= S_CLEAR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_drain_cnt <= 2'd0;
                    r_state     <= (r_remaining != '0) ? S_STREAM : S_DRAIN;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_res_data <= w_macc_out;
                        r_state    <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_drain_cnt <= 2'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    macc #(
        .TYPE      ("FIXED_POINT"),
        .OP_WIDTH  (OP_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_macc (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_accept),
        .clear   (r_state == S_CLEAR),
        .op_code (w_op_code),
        .op_0    (in_op_0),
        .op_1    (in_op_1),
        .op_add  ('0),
        .out     (w_macc_out)
    );

endmodule

// File: tb/tb_macc_seq.sv
// Directed bench for macc_seq: integer instance (FRAC_BITS=0) and fixed-point
// instance (FRAC_BITS=8) share all inputs; each test checks the relevant one.
module tb_macc_seq;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid, cmd_square, in_valid, res_ready;
    logic [15:0]        cmd_len;
    logic signed [15:0] in_op_0, in_op_1;

    logic               cmd_ready0, in_ready0, res_valid0;
    logic signed [15:0] res_data0;
    logic               cmd_ready8, in_ready8, res_valid8;
    logic signed [15:0] res_data8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    macc_seq #(.OP_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16), .FRAC_BITS(0), .LEN_W(16)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_len(cmd_len), .cmd_square(cmd_square), .in_valid(in_valid), .in_ready(in_ready0),
        .in_op_0(in_op_0), .in_op_1(in_op_1), .res_valid(res_valid0), .res_ready(res_ready),
        .res_data(res_data0)
    );

    macc_seq #(.OP_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16), .FRAC_BITS(8), .LEN_W(16)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
        .cmd_len(cmd_len), .cmd_square(cmd_square), .in_valid(in_valid), .in_ready(in_ready8),
        .in_op_0(in_op_0), .in_op_1(in_op_1), .res_valid(res_valid8), .res_ready(res_ready),
        .res_data(res_data8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command while IDLE; afterwards scramble cmd_* to show they are ignored.
    task automatic issue(input logic [15:0] len, input logic sq);
        cmd_valid  = 1'b1;
        cmd_len    = len;
        cmd_square = sq;
        tick();
        cmd_valid  = 1'b0;
        cmd_len    = 16'hBEEF;
        cmd_square = ~sq;
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op_0  = a;
        in_op_1  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready0 === 1'b1) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_accept: got no in_ready within 20 cycles, required accept");
        end
    endtask

    task automatic wait_res(output int cycles);
        cycles = -1;
        for (int i = 0; i < 40; i++) begin
            if (res_valid0 === 1'b1) begin
                cycles = i;
                break;
            end
            tick();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = 16'd0; cmd_square = 1'b0;
        in_valid = 1'b0; in_op_0 = 16'sd0; in_op_1 = 16'sd0; res_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        n_tests++;
        if (cmd_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready0); end
        n_tests++;
        if (res_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b required 0", res_valid0); end
        n_tests++;
        if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready0); end
        n_tests++;
        if (res_data0 !== 16'sd0) begin n_fail++; $display("FAIL reset_res_data: got %0d required 0", res_data0); end
    endtask

    task automatic test_dot();
        issue(16'd4, 1'b0);
        n_tests++;
        if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL dot_clear_in_ready: got %b required 0", in_ready0); end
        send(16'sd1, 16'sd2);
        send(16'sd3, 16'sd4);
        send(16'sd5, 16'sd6);
        send(16'sd7, 16'sd8);
        tick(); tick();
        n_tests++;
        if (res_valid0 !== 1'b0) begin n_fail++; $display("FAIL dot_early_valid: got %b required 0 at t+3", res_valid0); end
        tick();
        n_tests++;
        if (res_valid0 !== 1'b1) begin n_fail++; $display("FAIL dot_valid_t4: got %b required 1 at t+4", res_valid0); end
        n_tests++;
        if (res_data0 !== 16'sd100) begin n_fail++; $display("FAIL dot_data: got %0d required 100", res_data0); end
        handshake();
        n_tests++;
        if (cmd_ready0 !== 1'b1) begin n_fail++; $display("FAIL dot_idle_after: got %b required 1", cmd_ready0); end
    endtask

    task automatic test_square_bubbles();
        int cyc;
        issue(16'd3, 1'b1);
        send(16'sd2, 16'sd99);
        in_op_0 = 16'sd50;
        tick(); tick();
        send(16'sd3, 16'sd99);
        in_op_0 = 16'sd50;
        tick(); tick();
        send(16'sd4, 16'sd99);
        wait_res(cyc);
        n_tests++;
        if (cyc < 0) begin n_fail++; $display("FAIL sq_timeout: got no res_valid, required result"); end
        n_tests++;
        if (res_data0 !== 16'sd29) begin n_fail++; $display("FAIL sq_data: got %0d required 29", res_data0); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(16'd0, 1'b0);
        tick(); tick(); tick();
        n_tests++;
        if (res_valid0 !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b required 0 at c+4", res_valid0); end
        tick();
        n_tests++;
        if (res_valid0 !== 1'b1) begin n_fail++; $display("FAIL zero_valid_c5: got %b required 1 at c+5", res_valid0); end
        n_tests++;
        if (res_data0 !== 16'sd0) begin n_fail++; $display("FAIL zero_data: got %0d required 0", res_data0); end
        res_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_len    = 16'd2;
        cmd_square = 1'b0;
        tick();
        res_ready = 1'b0;
        n_tests++;
        if (cmd_ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got cmd_ready %b required 1", cmd_ready0); end
        tick();
        cmd_valid = 1'b0;
        cmd_len   = 16'd9;
        send(-16'sd3, 16'sd5);
        send(16'sd2, 16'sd2);
        wait_res(cyc);
        n_tests++;
        if (cyc < 0 || res_data0 !== -16'sd11) begin n_fail++; $display("FAIL b2b_data: got %0d (wait %0d) required -11", res_data0, cyc); end
        handshake();
    endtask

    task automatic test_fixed_point();
        int cyc;
        issue(16'd2, 1'b0);
        send(16'sh0180, 16'sh0200);
        send(16'sh0100, 16'sh0100);
        wait_res(cyc);
        n_tests++;
        if (cyc < 0 || res_valid8 !== 1'b1 || res_data8 !== 16'sh0400) begin
            n_fail++;
            $display("FAIL fixed_data: got 0x%h valid %b required 0x0400", res_data8, res_valid8);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(16'd1, 1'b0);
        send(16'sd5, 16'sd5);
        wait_res(cyc);
        res_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd_len    = 16'd1;
        cmd_square = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (res_valid0 !== 1'b1 || res_data0 !== 16'sd25 || cmd_ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid %b data %0d cmd_ready %b required 1/25/0",
                         i, res_valid0, res_data0, cmd_ready0);
            end
            tick();
        end
        handshake();
        n_tests++;
        if (cmd_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got cmd_ready %b required 1", cmd_ready0); end
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if (cmd_ready0 !== 1'b0 || in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_clear: got cmd_ready %b in_ready %b required 0/0", cmd_ready0, in_ready0);
        end
        send(16'sd4, 16'sd9);
        wait_res(cyc);
        n_tests++;
        if (cyc < 0 || res_data0 !== 16'sd16) begin n_fail++; $display("FAIL bp_next_data: got %0d required 16", res_data0); end
        handshake();
    endtask

    task automatic test_reset_midstream();
        int cyc;
        bit seen;
        issue(16'd5, 1'b0);
        send(16'sd1, 16'sd1);
        send(16'sd2, 16'sd2);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_tests++;
        if (cmd_ready0 !== 1'b1 || res_valid0 !== 1'b0 || in_ready0 !== 1'b0 || res_data0 !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got cmd_ready %b res_valid %b in_ready %b data %0d required 1/0/0/0",
                     cmd_ready0, res_valid0, in_ready0, res_data0);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid0 !== 1'b0) seen = 1'b1;
            tick();
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL rst_mid_phantom: got res_valid after reset, required none"); end
        issue(16'd1, 1'b0);
        send(16'sd6, 16'sd7);
        wait_res(cyc);
        n_tests++;
        if (cyc < 0 || res_data0 !== 16'sd42) begin n_fail++; $display("FAIL rst_mid_next: got %0d required 42", res_data0); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_dot();
        test_square_bubbles();
        test_back_to_back();
        test_fixed_point();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
